// File: rtl/vec_fp16_addsub.sv
// Multi-lane IEEE binary16 adder/subtractor with a two-stage valid/ready pipeline.
// S1 classifies, swaps, aligns and adds magnitudes; S2 normalizes, rounds (RNE) and packs.
module vec_fp16_addsub #(
  parameter int LANES = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                op_sub,
  input  logic [LANES-1:0]    lane_mask,
  input  logic [16*LANES-1:0] port_a,
  input  logic [16*LANES-1:0] port_b,
  output logic [16*LANES-1:0] out,
  output logic [LANES-1:0]    out_mask,
  output logic [LANES-1:0]    overflow,
  output logic [LANES-1:0]    invalid,
  output logic                out_valid,
  input  logic                out_ready
);

  logic             s1_valid_reg;
  logic [LANES-1:0] s1_mask_reg;
  logic             s2_adv;
  logic             s1_adv;
  logic             accept;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid_reg || s2_adv;
  assign in_ready = s1_adv;
  assign accept   = in_valid && s1_adv;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid_reg <= 1'b0;
      s1_mask_reg  <= '0;
      out_valid    <= 1'b0;
      out_mask     <= '0;
    end else begin
      if (s1_adv) s1_valid_reg <= in_valid;
      if (accept) s1_mask_reg <= lane_mask;
      if (s2_adv) out_valid <= s1_valid_reg;
      if (s2_adv && s1_valid_reg) out_mask <= s1_mask_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      // ---------------- stage 1: classify, swap, align, add ----------------
      logic [15:0] a;
      logic [15:0] b;
      logic        a_nan, b_nan, a_inf, b_inf;
      logic        sp_c, sp_inv_c;
      logic [15:0] sp_val_c;
      logic        swap;
      logic [4:0]  exp_a, exp_b, big_exp, sml_exp, diff;
      logic [10:0] big_sig, sml_sig;
      logic [13:0] sml_ext, aligned;
      logic        sticky;
      logic [14:0] mag_c;

      assign a     = port_a[16*gi +: 16];
      // The sign of b is flipped before anything looks at it, so subtraction is just addition.
      assign b     = {port_b[16*gi+15] ^ op_sub, port_b[16*gi +: 15]};
      assign a_nan = (&a[14:10]) && (|a[9:0]);
      assign b_nan = (&b[14:10]) && (|b[9:0]);
      assign a_inf = (&a[14:10]) && !(|a[9:0]);
      assign b_inf = (&b[14:10]) && !(|b[9:0]);

      always_comb begin
        sp_c     = 1'b0;
        sp_inv_c = 1'b0;
        sp_val_c = 16'h0000;
        if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15]))) begin
          sp_c     = 1'b1;
          sp_inv_c = 1'b1;
          sp_val_c = 16'h7E00;
        end else if (a_inf) begin
          sp_c     = 1'b1;
          sp_val_c = {a[15], 15'h7C00};
        end else if (b_inf) begin
          sp_c     = 1'b1;
          sp_val_c = {b[15], 15'h7C00};
        end
      end

      assign exp_a   = (a[14:10] == 5'd0) ? 5'd1 : a[14:10];
      assign exp_b   = (b[14:10] == 5'd0) ? 5'd1 : b[14:10];
      assign swap    = a[14:0] < b[14:0];
      assign big_sig = swap ? {|b[14:10], b[9:0]} : {|a[14:10], a[9:0]};
      assign sml_sig = swap ? {|a[14:10], a[9:0]} : {|b[14:10], b[9:0]};
      assign big_exp = swap ? exp_b : exp_a;
      assign sml_exp = swap ? exp_a : exp_b;
      assign diff    = big_exp - sml_exp;
      assign sml_ext = {sml_sig, 3'b000};

      // Three extra bits (guard, round, sticky); every bit shifted out is folded into sticky.
      always_comb begin
        if (diff >= 5'd14) begin
          aligned = '0;
          sticky  = |sml_sig;
        end else begin
          aligned = sml_ext >> diff;
          sticky  = |(sml_ext & ~(14'h3FFF << diff));
        end
      end

      always_comb begin
        if (a[15] ^ b[15])
          mag_c = {1'b0, big_sig, 3'b000} - {1'b0, aligned[13:1], aligned[0] | sticky};
        else
          mag_c = {1'b0, big_sig, 3'b000} + {1'b0, aligned[13:1], aligned[0] | sticky};
      end

      logic        s1_sp_reg, s1_inv_reg, s1_sign_reg, s1_zsign_reg;
      logic [15:0] s1_sp_val_reg;
      logic [4:0]  s1_exp_reg;
      logic [14:0] s1_mag_reg;

      always_ff @(posedge CLK) begin
        if (accept) begin
          s1_sp_reg     <= sp_c;
          s1_inv_reg    <= sp_inv_c;
          s1_sp_val_reg <= sp_val_c;
          s1_sign_reg   <= swap ? b[15] : a[15];
          s1_zsign_reg  <= a[15] & b[15];
          s1_exp_reg    <= big_exp;
          s1_mag_reg    <= mag_c;
        end
      end

      // ---------------- stage 2: normalize, round, pack ----------------
      logic [3:0]  lz;
      logic [4:0]  lz5, exp_m1, sh;
      logic [13:0] n;
      logic [5:0]  norm_exp, e_field;
      logic        rnd;
      logic [15:0] packed_c;
      logic [15:0] res_c;
      logic        ovf_c, inv_c;

      always_comb begin
        lz = 4'd0;
        for (int k = 0; k < 14; k++)
          if (s1_mag_reg[k]) lz = 4'(13 - k);
      end

      // Left shift stops at exponent 1 so tiny results come out as subnormals.
      assign lz5    = {1'b0, lz};
      assign exp_m1 = s1_exp_reg - 5'd1;
      assign sh     = (lz5 < exp_m1) ? lz5 : exp_m1;

      always_comb begin
        if (s1_mag_reg[14]) begin
          n        = {s1_mag_reg[14:2], |s1_mag_reg[1:0]};
          norm_exp = {1'b0, s1_exp_reg} + 6'd1;
        end else begin
          n        = s1_mag_reg[13:0] << sh;
          norm_exp = {1'b0, s1_exp_reg} - {1'b0, sh};
        end
      end

      // A rounding carry ripples into the exponent field, covering subnormal->normal and overflow.
      assign e_field  = n[13] ? norm_exp : 6'd0;
      assign rnd      = n[2] & (n[3] | n[1] | n[0]);
      assign packed_c = {e_field, n[12:3]} + {15'd0, rnd};

      always_comb begin
        res_c = {s1_sign_reg, packed_c[14:0]};
        ovf_c = 1'b0;
        inv_c = 1'b0;
        if (!s1_mask_reg[gi]) begin
          res_c = 16'h0000;
        end else if (s1_sp_reg) begin
          res_c = s1_sp_val_reg;
          inv_c = s1_inv_reg;
        end else if (s1_mag_reg == 15'd0) begin
          res_c = {s1_zsign_reg, 15'd0};
        end else if (packed_c[15:10] >= 6'd31) begin
          res_c = {s1_sign_reg, 15'h7C00};
          ovf_c = 1'b1;
        end
      end

      logic [15:0] res_reg;
      logic        ovf_reg, inv_reg;

      always_ff @(posedge CLK) begin
        if (RST) begin
          res_reg <= 16'h0000;
          ovf_reg <= 1'b0;
          inv_reg <= 1'b0;
        end else if (s2_adv && s1_valid_reg) begin
          res_reg <= res_c;
          ovf_reg <= ovf_c;
          inv_reg <= inv_c;
        end
      end

      assign out[16*gi +: 16] = res_reg;
      assign overflow[gi]     = ovf_reg;
      assign invalid[gi]      = inv_reg;
    end
  endgenerate

endmodule

// File: tb/tb_vec_fp16_addsub.sv
// Randomized bench for vec_fp16_addsub with a real-arithmetic reference model and scoreboard.
module tb_vec_fp16_addsub;
  localparam int L = 4;

  logic           CLK = 1'b0;
  logic           RST;
  logic           in_valid, in_ready, op_sub, out_valid, out_ready;
  logic [L-1:0]   lane_mask, out_mask, overflow, invalid;
  logic [16*L-1:0] port_a, port_b, out;

  vec_fp16_addsub #(.LANES(L)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .op_sub(op_sub),
    .lane_mask(lane_mask), .port_a(port_a), .port_b(port_b), .out(out), .out_mask(out_mask),
    .overflow(overflow), .invalid(invalid), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [16*L-1:0] val;
    logic [L-1:0]    msk, ovf, inv;
    int              acc;
    bit              lat;
    bit              lit_en;
    int              lit_lane;
    logic [17:0]     lit;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0, errors = 0, cyc = 0, rst_run = 0, nout = 0;
  bit   pinned = 0, prev_hold = 0, chk_lat = 1, rand_rdy = 0;
  bit   lit_en = 0;
  int   lit_lane = 0;
  logic [17:0]  lit_exp = '0;
  logic [127:0] prev_vec = '0;

  always @(posedge CLK) begin
    cyc     <= cyc + 1;
    rst_run <= RST ? rst_run + 1 : 0;
  end

  // ---------------- reference model ----------------
  function automatic real pow2(input int k);
    real r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else        for (int i = 0; i < -k; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real f2r(input logic [15:0] h);
    int  e = int'(h[14:10]);
    int  m = int'(h[9:0]);
    real v;
    if (e == 0) v = m * pow2(-24);
    else        v = (m + 1024) * pow2(e - 25);
    return h[15] ? -v : v;
  endfunction

  // Returns {overflow, invalid, value}; x is nonzero and finite.
  function automatic logic [17:0] r2f(input real x);
    logic s;
    real  m, ulp, q, fr;
    int   e, fl;
    logic [15:0] h;
    s = (x < 0.0);
    m = s ? -x : x;
    if (m >= 65520.0) return {2'b10, s, 15'h7C00};
    e = -14;
    while (e < 15 && m >= pow2(e + 1)) e++;
    ulp = pow2(e - 10);
    q   = m / ulp;
    fl  = $rtoi(q);
    fr  = q - fl;
    if (fr > 0.5 || (fr == 0.5 && (fl % 2) == 1)) fl++;
    if (fl == 2048) begin e++; fl = 1024; end
    if (fl < 1024) h = {s, 5'd0, 10'(fl)};
    else           h = {s, 5'(e + 15), 10'(fl - 1024)};
    return {2'b00, h};
  endfunction

  function automatic logic [17:0] model_lane(input logic [15:0] a, input logic [15:0] b0, input logic sub);
    logic [15:0] b;
    bit  an, bn, ai, bi;
    real s;
    b  = b0;
    if (sub) b[15] = ~b[15];
    an = (a[14:10] == 5'h1F) && (a[9:0] != 0);
    bn = (b[14:10] == 5'h1F) && (b[9:0] != 0);
    ai = (a[14:10] == 5'h1F) && (a[9:0] == 0);
    bi = (b[14:10] == 5'h1F) && (b[9:0] == 0);
    if (an || bn) return 18'h17E00;
    if (ai && bi) return (a[15] != b[15]) ? 18'h17E00 : {2'b00, a};
    if (ai) return {2'b00, a};
    if (bi) return {2'b00, b};
    s = f2r(a) + f2r(b);
    if (s == 0.0) return (a[15] && b[15]) ? 18'h08000 : 18'h00000;
    return r2f(s);
  endfunction

  function automatic exp_t model_beat(input logic [16*L-1:0] a, input logic [16*L-1:0] b,
                                      input logic sub, input logic [L-1:0] m);
    exp_t e;
    logic [17:0] r;
    e.val = '0; e.ovf = '0; e.inv = '0; e.msk = m;
    for (int i = 0; i < L; i++) begin
      if (m[i]) begin
        r = model_lane(a[16*i +: 16], b[16*i +: 16], sub);
        e.val[16*i +: 16] = r[15:0];
        e.inv[i] = r[16];
        e.ovf[i] = r[17];
      end
    end
    return e;
  endfunction

  // ---------------- compare process ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (!pinned) begin
      chk("model 3C00+3C00", model_lane(16'h3C00, 16'h3C00, 1'b0), 18'h04000);
      chk("model rne tie",   model_lane(16'h3C00, 16'h1000, 1'b0), 18'h03C00);
      chk("model rne up",    model_lane(16'h3C01, 16'h1000, 1'b0), 18'h03C02);
      chk("model overflow",  model_lane(16'h7BFF, 16'h7BFF, 1'b0), 18'h27C00);
      chk("model inf-inf",   model_lane(16'h7C00, 16'h7C00, 1'b1), 18'h17E00);
      chk("model subnormal", model_lane(16'h0001, 16'h0001, 1'b0), 18'h00002);
      chk("model x-x",       model_lane(16'h3C00, 16'h3C00, 1'b1), 18'h00000);
      chk("model -0+-0",     model_lane(16'h8000, 16'h8000, 1'b0), 18'h08000);
      pinned = 1;
    end
    if (RST) begin
      sbq.delete();
      prev_hold = 0;
      if (rst_run > 0)
        chk("reset state", {out_valid, out, out_mask, overflow, invalid}, '0);
    end else begin
      chk("in_ready", in_ready, (sbq.size() < 2) || out_ready);
      if (prev_hold)
        chk("hold stable", {out_valid, out, out_mask, overflow, invalid}, prev_vec);
      if (out_valid && sbq.size() == 0) begin
        chk("spurious out_valid", out_valid, 1'b0);
      end else if (out_valid && out_ready) begin
        e = sbq.pop_front();
        nout++;
        chk("out", out, e.val);
        chk("out_mask", out_mask, e.msk);
        chk("flags", {overflow, invalid}, {e.ovf, e.inv});
        if (e.lit_en)
          chk("literal lane", {overflow[e.lit_lane], invalid[e.lit_lane], out[16*e.lit_lane +: 16]}, e.lit);
        if (e.lat) chk("latency", cyc - e.acc, 2);
        $display("result %0d: out=%h mask=%b ovf=%b inv=%b", nout, out, out_mask, overflow, invalid);
      end
      if (in_valid && in_ready) begin
        e          = model_beat(port_a, port_b, op_sub, lane_mask);
        e.acc      = cyc;
        e.lat      = chk_lat;
        e.lit_en   = lit_en;
        e.lit_lane = lit_lane;
        e.lit      = lit_exp;
        sbq.push_back(e);
      end
      prev_hold = out_valid && !out_ready;
      prev_vec  = {51'd0, out_valid, out, out_mask, overflow, invalid};
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [15:0] rnd_h();
    logic [15:0] sp [10] = '{16'h7C00, 16'hFC00, 16'h7E00, 16'h7C01, 16'h0000,
                             16'h8000, 16'h0001, 16'h8001, 16'h7BFF, 16'hFBFF};
    case ($urandom_range(0, 9))
      0:       return sp[$urandom_range(0, 9)];
      1:       return {1'($urandom), 5'd0, 10'($urandom)};
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 2) != 0);
  endtask

  task automatic rand_inputs();
    logic [15:0] a;
    for (int i = 0; i < L; i++) begin
      a = rnd_h();
      port_a[16*i +: 16] = a;
      port_b[16*i +: 16] = ($urandom_range(0, 3) == 0) ? (a ^ 16'($urandom_range(0, 31)) ^ 16'h8000) : rnd_h();
    end
    op_sub    = 1'($urandom);
    lane_mask = ($urandom_range(0, 3) == 0) ? L'($urandom) : '1;
  endtask

  task automatic wait_accept();
    bit acc;
    int t = 0;
    forever begin
      @(negedge CLK);
      acc = in_ready;
      step();
      if (acc) break;
      t++;
      if (t > 60) begin
        $display("FAIL accept timeout: in_ready stuck low at cycle %0d", cyc);
        $fatal(1, "bench stopped");
      end
    end
    in_valid = 1'b0;
    lit_en   = 0;
  endtask

  task automatic setup_dir(input logic [15:0] a0, input logic [15:0] b0, input logic op,
                           input logic [L-1:0] m, input int lane, input logic [17:0] lit);
    rand_inputs();
    port_a[16*lane +: 16] = a0;
    port_b[16*lane +: 16] = b0;
    op_sub    = op;
    lane_mask = m;
    lit_en    = 1;
    lit_lane  = lane;
    lit_exp   = lit;
    in_valid  = 1'b1;
  endtask

  task automatic dir(input logic [15:0] a0, input logic [15:0] b0, input logic op,
                     input logic [L-1:0] m, input int lane, input logic [17:0] lit);
    setup_dir(a0, b0, op, m, lane, lit);
    wait_accept();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      rand_inputs();
      step();
    end
  endtask

  task automatic drain();
    int t = 0;
    in_valid = 1'b0;
    while (sbq.size() != 0 || out_valid) begin
      step();
      t++;
      if (t > 200) begin
        $display("FAIL drain timeout: %0d beats outstanding at cycle %0d", sbq.size(), cyc);
        $fatal(1, "bench stopped");
      end
    end
  endtask

  initial begin
    RST = 1'b1; in_valid = 1'b0; op_sub = 1'b0; lane_mask = '0;
    port_a = '0; port_b = '0; out_ready = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;

    // Directed corner beats, lane 0 (lane 1 for masking).
    dir(16'h3C00, 16'h3C00, 1'b0, '1, 0, 18'h04000);
    dir(16'h3C00, 16'h1000, 1'b0, '1, 0, 18'h03C00);
    dir(16'h3C01, 16'h1000, 1'b0, '1, 0, 18'h03C02);
    dir(16'h7BFF, 16'h7BFF, 1'b0, '1, 0, 18'h27C00);
    dir(16'h7C00, 16'h7C00, 1'b1, '1, 0, 18'h17E00);
    dir(16'h0001, 16'h0001, 1'b0, '1, 0, 18'h00002);
    dir(16'h3C00, 16'h3C00, 1'b1, '1, 0, 18'h00000);
    dir(16'h8000, 16'h8000, 1'b0, '1, 0, 18'h08000);
    dir(16'h7C00, 16'h7C00, 1'b1, 4'b0101, 1, 18'h00000);
    dir(16'h7C00, 16'h3C00, 1'b1, 4'b0101, 3, 18'h00000);
    drain();

    // Backpressure: two beats fill the pipe, the third waits until out_ready returns.
    chk_lat = 0;
    out_ready = 1'b0;
    dir(16'h3C00, 16'h3C00, 1'b0, '1, 0, 18'h04000);
    dir(16'h4000, 16'h3C00, 1'b0, '1, 0, 18'h04200);
    setup_dir(16'h4200, 16'h3C00, 1'b0, '1, 0, 18'h04400);
    repeat (4) @(posedge CLK);
    #1 out_ready = 1'b1;
    wait_accept();
    drain();

    // Random beats, full throughput with latency checked.
    chk_lat = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        rand_inputs();
        lit_en = 0;
        in_valid = 1'b1;
        wait_accept();
      end else idle(1);
    end
    drain();

    // Random beats under random backpressure.
    chk_lat = 0;
    rand_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        rand_inputs();
        lit_en = 0;
        in_valid = 1'b1;
        wait_accept();
      end else idle(1);
    end
    rand_rdy = 0;
    out_ready = 1'b1;
    drain();

    // Reset with two beats in flight; nothing stale may emerge afterwards.
    out_ready = 1'b0;
    dir(16'h3C00, 16'h3C00, 1'b0, '1, 0, 18'h04000);
    dir(16'h3C00, 16'h4000, 1'b0, '1, 0, 18'h04200);
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    out_ready = 1'b1;
    idle(5);
    chk_lat = 1;
    for (int i = 0; i < 20; i++) begin
      rand_inputs();
      lit_en = 0;
      in_valid = 1'b1;
      wait_accept();
    end
    drain();
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vec_fp16_addsub.md
VEC_FP16_ADDSUB -- requirements
Module: vec_fp16_addsub

Interface
REQ-001 SHALL have parameter LANES, default 4, meaning the number of independent FP16 lanes (legal range 1..16).
REQ-002 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, meaning the input beat is presented.
REQ-005 SHALL have port in_ready, output, 1, meaning the block accepts the beat this cycle.
REQ-006 SHALL have port op_sub, input, 1: 0 computes a+b, 1 computes a-b, for all lanes of the beat.
REQ-007 SHALL have port lane_mask, input, LANES, meaning per-lane enable.
REQ-008 SHALL have ports port_a and port_b, input, 16*LANES each; lane i occupies bits [16i+15:16i], IEEE binary16.
REQ-009 SHALL have port out, output, 16*LANES, the per-lane result.
REQ-010 SHALL have port out_mask, output, LANES, the lane_mask carried with the beat.
REQ-011 SHALL have ports overflow and invalid, output, LANES each, meaning per-lane exception flags.
REQ-012 SHALL have port out_valid, output, 1, and port out_ready, input, 1, forming a valid/ready output handshake.

Function
REQ-013 SHALL accept a beat when in_valid && in_ready, and transfer a result when out_valid && out_ready.
REQ-014 SHALL have two register stages: S1 (classify, swap, align, add/sub magnitude) and S2 (normalize, round, pack).
REQ-015 SHALL advance S2 when !out_valid || out_ready, advance S1 when S1 is empty or S2 advances, and drive in_ready = S1 advance (combinational, no dependence on in_valid).
REQ-016 SHALL give a latency of exactly 2 cycles from acceptance to out_valid when out_ready stays high, with sustained throughput of 1 beat/cycle.
REQ-017 SHALL hold out, out_mask, flags and out_valid stable while out_valid && !out_ready; no beat is dropped or duplicated; at most 2 beats are in flight.
REQ-018 SHALL, when op_sub=1, invert the sign of b before classification; this applies to Inf, zero and subnormals as well.
REQ-019 SHALL round to nearest-even using guard/round/sticky bits, with a sticky bit collected from all alignment shifts.
REQ-020 SHALL accept subnormal inputs (effective exponent 1, hidden bit 0) and produce subnormal outputs without flushing.
REQ-021 SHALL output canonical NaN 0x7E00 with invalid=1 when an operand is NaN or the operation is effectively Inf-Inf.
REQ-022 SHALL output a correctly signed Inf, with flags 0, when exactly one effective operand is Inf.
REQ-023 SHALL output a signed Inf with overflow=1 when the rounded exponent is 31 or more.
REQ-024 SHALL output +0 for an exact-zero effective subtraction, and -0 only when both effective operands are -0.
REQ-025 SHALL, for a masked lane (lane_mask[i]=0), output 0x0000 with both flags 0, independent of that lane's operands.
REQ-026 SHALL compute all lanes identically and independently; no lane's result depends on another lane.
REQ-027 SHALL compute a new result only on acceptance, never on data presented with in_valid low.

Reset
REQ-028 SHALL, while RST=1 at a clock edge, clear both stage valids, out_valid=0, out=0, out_mask=0, overflow=0 and invalid=0.
REQ-029 SHALL, when reset is asserted mid-operation, discard all in-flight beats; in_ready=1 on the first cycle after RST deasserts.

Verification
REQ-030 SHALL cover lane0 0x3C00+0x3C00 with op_sub=0 and out_ready=1: out lane0=0x4000 exactly 2 cycles after acceptance.
REQ-031 SHALL cover round-to-nearest-even: 0x3C00+0x1000 gives 0x3C00 (tie to even); 0x3C01+0x1000 gives 0x3C02.
REQ-032 SHALL cover exceptions: 0x7BFF+0x7BFF gives 0x7C00 with overflow=1; 0x7C00 with op_sub=1 and 0x7C00 gives 0x7E00 with invalid=1; 0x0001+0x0001 gives 0x0002.
REQ-033 SHALL cover zero sign and masking: 0x3C00-0x3C00 gives 0x0000; 0x8000+0x8000 gives 0x8000; lane_mask=4'b0101 gives lanes 1 and 3 = 0x0000 with flags 0.
REQ-034 SHALL cover backpressure: hold out_ready=0, drive 3 back-to-back beats; 2 are accepted, then in_ready=0 and out is stable; release out_ready to get 3 in-order results with no loss.
REQ-035 SHALL cover reset mid-operation: assert RST with 2 beats in flight; out_valid=0 the next cycle and no stale beat appears afterwards.
